// File: rtl/ram_port_arbiter.sv
// rtl/ram_port_arbiter.sv - round-robin arbiter sharing one data-RAM port among three requesters
// Optional per-requester grant-cycle counters enabled by ARB_STATS_EN.
module ram_port_arbiter #(
    parameter int ADDR_WIDTH = 12,
    parameter int HOLD_MAX   = 16
) (
    input  logic                      CLK,
    input  logic                      RST_N,
    input  logic [2:0]                req,
    input  logic [2:0]                lock,
    input  logic [2:0]                we_in,
    input  logic [3*ADDR_WIDTH-1:0]   addr_in,
    output logic [2:0]                gnt,
    output logic [ADDR_WIDTH-1:0]     ram_addr,
    output logic                      ram_we,
    output logic                      ram_oe,
    output logic                      busy
`ifdef ARB_STATS_EN
    ,
    output logic [47:0]               stats
`endif
);

    typedef enum logic [1:0] {IDLE, GRANT, TURN} state_t;

    localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

    state_t     state_q, state_d;
    logic [2:0] gnt_q, gnt_d;
    logic [1:0] rr_ptr_q, rr_ptr_d;
    logic [7:0] tenure_q, tenure_d;

    logic [1:0] owner;
    logic [1:0] cand0, cand1, cand2;
    logic [1:0] winner;
    logic       owner_done;

    assign owner = gnt_q[1] ? 2'd1 : (gnt_q[2] ? 2'd2 : 2'd0);

    // Search order starts at rr_ptr and wraps 2 -> 0.
    assign cand0 = rr_ptr_q;
    assign cand1 = (cand0 == 2'd2) ? 2'd0 : cand0 + 2'd1;
    assign cand2 = (cand1 == 2'd2) ? 2'd0 : cand1 + 2'd1;

    always_comb begin
        winner = cand0;
        if (req[cand0])      winner = cand0;
        else if (req[cand1]) winner = cand1;
        else if (req[cand2]) winner = cand2;
    end

    assign owner_done = !req[owner] || (!lock[owner] && tenure_q == HOLD_LAST);

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        rr_ptr_d = rr_ptr_q;
        tenure_d = tenure_q;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    gnt_d    = 3'b001 << winner;
                    tenure_d = 8'd0;
                    state_d  = GRANT;
                end
            end
            GRANT: begin
                if (tenure_q != 8'hFF) tenure_d = tenure_q + 8'd1;
                if (owner_done) begin
                    gnt_d    = 3'b000;
                    rr_ptr_d = (owner == 2'd2) ? 2'd0 : owner + 2'd1;
                    state_d  = TURN;
                end
            end
            TURN: begin
                gnt_d   = 3'b000;
                state_d = IDLE;
            end
            default: begin
                gnt_d   = 3'b000;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= IDLE;
            gnt_q    <= 3'b000;
            rr_ptr_q <= 2'd0;
            tenure_q <= 8'd0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            rr_ptr_q <= rr_ptr_d;
            tenure_q <= tenure_d;
        end
    end

    // Datapath follows the registered grant so the RAM sees a clean owner change.
    logic [ADDR_WIDTH-1:0] owner_addr;
    always_comb begin
        case (owner)
            2'd1:    owner_addr = addr_in[1*ADDR_WIDTH +: ADDR_WIDTH];
            2'd2:    owner_addr = addr_in[2*ADDR_WIDTH +: ADDR_WIDTH];
            default: owner_addr = addr_in[0 +: ADDR_WIDTH];
        endcase
    end

    assign gnt      = gnt_q;
    assign ram_addr = (|gnt_q) ? owner_addr : '0;
    assign ram_we   = (|gnt_q) &  we_in[owner];
    assign ram_oe   = (|gnt_q) & ~we_in[owner];
    assign busy     = (state_q != IDLE);

`ifdef ARB_STATS_EN
    logic [15:0] cnt_q [3];
    for (genvar i = 0; i < 3; i++) begin : g_stats
        always_ff @(posedge CLK or negedge RST_N) begin
            if (!RST_N)
                cnt_q[i] <= 16'd0;
            else if (gnt_q[i] && cnt_q[i] != 16'hFFFF)
                cnt_q[i] <= cnt_q[i] + 16'd1;
        end
        assign stats[i*16 +: 16] = cnt_q[i];
    end
`endif

endmodule
